step_dir_generator: RTL

Downstream stage of the gearbox. Takes single-cycle motor step requests with a direction bit and produces driver-legal STEP/DIR outputs for the stepper driver. Requests are queued in a signed net-step counter. A timing FSM enforces the direction setup time, the step high width and the minimum step low time. The gearbox only emits requests; this block owns all pulse shaping.

---
 rtl/step_gen_pkg.sv | 23 ++
 rtl/step_dir_generator_phase_timer.sv | 29 ++
 rtl/step_dir_generator.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/step_gen_pkg.sv
// Shared types and helpers for the step/dir pulse generator.
// Holds the FSM state encoding and the timer width calculation.
// No ports; imported by step_dir_generator and phase_timer.
package step_gen_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_DIR_SETUP  = 2'd1;
  localparam state_t ST_PULSE_HIGH = 2'd2;
  localparam state_t ST_PULSE_LOW  = 2'd3;

  // One spare bit above the largest tick count so every load value fits
  // without truncation, including power-of-two tick counts.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/step_dir_generator_phase_timer.sv
// Loadable down-counter shared by the DIR_SETUP, PULSE_HIGH and PULSE_LOW phases.
// Latency: load takes effect on the next edge; done is combinational (count == 0).
// No backpressure: counts down by one per cycle until it reaches zero and holds.
// Ports: clk, reset (sync, active-high), load/load_val (restart), done (count is zero).
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/step_dir_generator.sv
// Turns single-cycle step requests into driver-legal STEP/DIR pulses via a
// signed pending-step queue and a setup/high/low timing FSM.
// Latency: a request sampled at edge N with matching direction raises step_out at N+2.
// Backpressure: none upstream; requests always queue, and a request that would
// saturate the queue is dropped and latched in the sticky overflow flag.
// Optional: define STEP_COUNTER_EN to add the motor_position output and counter.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   step_req, step_dir    one-cycle request and its direction (1 = forward)
//   enable                1 allows new pulses / direction changes to start
//   overflow_clr          clears the sticky overflow flag
//   step_out, dir_out     registered STEP/DIR to the driver
//   busy                  FSM active or steps still queued
//   pending               signed net queued steps
//   overflow              sticky dropped-request flag
//   motor_position        signed emitted-step count (STEP_COUNTER_EN only)
module step_dir_generator
  import step_gen_pkg::*;
#(
  parameter int STEP_PULSE_TICKS = 120,
  parameter int STEP_LOW_TICKS   = 120,
  parameter int DIR_SETUP_TICKS  = 60,
  parameter int PENDING_BITS     = 8,
  parameter int COUNT_BITS       = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_req,
  input  logic                    step_dir,
  input  logic                    enable,
  input  logic                    overflow_clr,
  output logic                    step_out,
  output logic                    dir_out,
  output logic                    busy,
  output logic [PENDING_BITS-1:0] pending,
  output logic                    overflow
`ifdef STEP_COUNTER_EN
  ,
  output logic [COUNT_BITS-1:0]   motor_position
`endif
);

  localparam int TW = timer_width(STEP_PULSE_TICKS, STEP_LOW_TICKS, DIR_SETUP_TICKS);

  // The FSM leaves a timed state on the cycle it observes done, so the high
  // and low phases load N-1 to last exactly N cycles. DIR_SETUP loads the full
  // count, which puts the rising edge DIR_SETUP_TICKS+1 edges after dir_out moves.
  localparam logic [TW-1:0] LD_DIR  = TW'(DIR_SETUP_TICKS);
  localparam logic [TW-1:0] LD_HIGH = TW'(STEP_PULSE_TICKS - 1);
  localparam logic [TW-1:0] LD_LOW  = TW'(STEP_LOW_TICKS - 1);

  // Queue arithmetic is done one bit wider so out-of-range sums are visible.
  localparam int PW = PENDING_BITS + 1;
  localparam logic signed [PW-1:0] PEND_MAX = PW'((1 << (PENDING_BITS - 1)) - 1);
  localparam logic signed [PW-1:0] PEND_MIN = -PEND_MAX;
  localparam logic signed [PW-1:0] D_POS    = PW'(1);
  localparam logic signed [PW-1:0] D_NEG    = '1;
  localparam logic signed [PW-1:0] D_ZERO   = '0;

  state_t                   state;
  state_t                   state_nxt;
  logic                     step_nxt;
  logic                     dir_nxt;
  logic                     consume;
  logic                     tmr_load;
  logic [TW-1:0]            tmr_val;
  logic                     tmr_done;
  logic                     req_q;
  logic                     req_dir_q;
  logic                     pend_zero;
  logic                     pend_pos;
  logic signed [PW-1:0]     pend_ext;
  logic signed [PW-1:0]     req_delta;
  logic signed [PW-1:0]     cons_delta;
  logic signed [PW-1:0]     sum_noreq;
  logic signed [PW-1:0]     sum_all;
  logic                     ovf_evt;
  logic [PENDING_BITS-1:0]  pend_nxt;

  phase_timer #(
    .WIDTH(TW)
  ) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign pend_zero = (pending == '0);
  assign pend_pos  = !pending[PENDING_BITS-1] && !pend_zero;

  // Timing FSM. dir_out only moves when leaving IDLE or at DIR_SETUP expiry.
  always_comb begin
    state_nxt = state;
    step_nxt  = step_out;
    dir_nxt   = dir_out;
    consume   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_IDLE: begin
        if (enable && !pend_zero) begin
          if (pend_pos == dir_out) begin
            state_nxt = ST_PULSE_HIGH;
            step_nxt  = 1'b1;
            consume   = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = LD_HIGH;
          end else begin
            state_nxt = ST_DIR_SETUP;
            dir_nxt   = pend_pos;
            tmr_load  = 1'b1;
            tmr_val   = LD_DIR;
          end
        end
      end
      ST_DIR_SETUP: begin
        if (tmr_done) begin
          // Dropping enable mid-setup parks in IDLE; dir_out is already
          // settled, so a later start from IDLE can pulse immediately.
          if (pend_zero || !enable) begin
            state_nxt = ST_IDLE;
          end else if (pend_pos == dir_out) begin
            state_nxt = ST_PULSE_HIGH;
            step_nxt  = 1'b1;
            consume   = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = LD_HIGH;
          end else begin
            dir_nxt  = pend_pos;
            tmr_load = 1'b1;
            tmr_val  = LD_DIR;
          end
        end
      end
      ST_PULSE_HIGH: begin
        if (tmr_done) begin
          state_nxt = ST_PULSE_LOW;
          step_nxt  = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = LD_LOW;
        end
      end
      ST_PULSE_LOW: begin
        if (tmr_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        step_nxt  = 1'b0;
      end
    endcase
  end

  // Queue update: the incoming request and the consumed step are applied in
  // the same cycle. Only the request is dropped when the sum would leave the
  // symmetric range; the consume always lands.
  assign pend_ext   = $signed({pending[PENDING_BITS-1], pending});
  assign req_delta  = !req_q   ? D_ZERO : (req_dir_q ? D_POS : D_NEG);
  assign cons_delta = !consume ? D_ZERO : (pend_pos  ? D_NEG : D_POS);
  assign sum_noreq  = pend_ext + cons_delta;
  assign sum_all    = sum_noreq + req_delta;
  assign ovf_evt    = req_q && ((sum_all > PEND_MAX) || (sum_all < PEND_MIN));
  assign pend_nxt   = ovf_evt ? sum_noreq[PENDING_BITS-1:0] : sum_all[PENDING_BITS-1:0];

  // step_req is registered on entry, which gives the two-edge request-to-pulse latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      step_out  <= 1'b0;
      dir_out   <= 1'b1;
      pending   <= '0;
      overflow  <= 1'b0;
      req_q     <= 1'b0;
      req_dir_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_out  <= step_nxt;
      dir_out   <= dir_nxt;
      pending   <= pend_nxt;
      req_q     <= step_req;
      req_dir_q <= step_dir;
      // A fresh drop outranks a clear arriving in the same cycle.
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE) || !pend_zero;

`ifdef STEP_COUNTER_EN
  // Counts on the edge that raises step_out; dir_out is stable at that point.
  always_ff @(posedge clk) begin
    if (reset) begin
      motor_position <= '0;
    end else if (consume) begin
      if (dir_out) begin
        motor_position <= motor_position + COUNT_BITS'(1);
      end else begin
        motor_position <= motor_position - COUNT_BITS'(1);
      end
    end
  end
`else
`endif

endmodule
